// File: rtl/fbdev_pi1arb.sv
// Two-master PI1 arbiter: framebuffer fetch (s0) has priority, s1 is the secondary.
// A hold counter masks an owner that keeps streaming while the other master waits.
module fbdev_pi1arb #(
    parameter int XARCHBITSZ = 32,
    parameter int HOLDMAX    = 16
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [1:0]                                    s0_pi1_op_i,
    input  logic [XARCHBITSZ-$clog2(XARCHBITSZ/8)-1:0]    s0_pi1_addr_i,
    input  logic [XARCHBITSZ-1:0]                         s0_pi1_data_i,
    output logic [XARCHBITSZ-1:0]                         s0_pi1_data_o,
    input  logic [XARCHBITSZ/8-1:0]                       s0_pi1_sel_i,
    output logic                                          s0_pi1_rdy_o,
    input  logic [1:0]                                    s1_pi1_op_i,
    input  logic [XARCHBITSZ-$clog2(XARCHBITSZ/8)-1:0]    s1_pi1_addr_i,
    input  logic [XARCHBITSZ-1:0]                         s1_pi1_data_i,
    output logic [XARCHBITSZ-1:0]                         s1_pi1_data_o,
    input  logic [XARCHBITSZ/8-1:0]                       s1_pi1_sel_i,
    output logic                                          s1_pi1_rdy_o,
    output logic [1:0]                                    m_pi1_op_o,
    output logic [XARCHBITSZ-$clog2(XARCHBITSZ/8)-1:0]    m_pi1_addr_o,
    output logic [XARCHBITSZ-1:0]                         m_pi1_data_o,
    input  logic [XARCHBITSZ-1:0]                         m_pi1_data_i,
    output logic [XARCHBITSZ/8-1:0]                       m_pi1_sel_o,
    input  logic                                          m_pi1_rdy_i,
    output logic [1:0]                                    gnt_o
);
    localparam int XADDRBITSZ = XARCHBITSZ - $clog2(XARCHBITSZ/8);
    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [7:0] HOLDLIM = 8'(HOLDMAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_pend;
    logic   r_pown;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;

    logic                  w_granted;
    logic                  w_own;
    logic [1:0]            w_own_op;
    logic [1:0]            w_oth_op;
    logic                  w_masked;
    logic                  w_accept;
    logic                  w_handover;

    assign w_granted = (r_state != IDLE);
    assign w_own     = (r_state == GNT1);
    assign w_own_op  = w_own ? s1_pi1_op_i : s0_pi1_op_i;
    assign w_oth_op  = w_own ? s0_pi1_op_i : s1_pi1_op_i;
    assign w_masked  = w_granted && (r_hold >= HOLDLIM) && (w_oth_op != PINOOP);
    assign w_accept  = (m_pi1_op_o != PINOOP) && m_pi1_rdy_i;
    // Handover only when nothing is accepted now and any outstanding response completes.
    assign w_handover = w_granted && ((w_own_op == PINOOP) || w_masked) &&
                        (!r_pend || m_pi1_rdy_i);

    always_comb begin
        m_pi1_op_o   = PINOOP;
        m_pi1_addr_o = '0;
        m_pi1_data_o = '0;
        m_pi1_sel_o  = '0;
        if (w_granted && !w_masked) begin
            m_pi1_op_o   = w_own_op;
            m_pi1_addr_o = w_own ? s1_pi1_addr_i : s0_pi1_addr_i;
            m_pi1_data_o = w_own ? s1_pi1_data_i : s0_pi1_data_i;
            m_pi1_sel_o  = w_own ? s1_pi1_sel_i  : s0_pi1_sel_i;
        end
    end

    assign s0_pi1_data_o = m_pi1_data_i;
    assign s1_pi1_data_o = m_pi1_data_i;
    assign s0_pi1_rdy_o  = m_pi1_rdy_i &
                           (((r_state == GNT0) && !w_masked) || (r_pend && !r_pown));
    assign s1_pi1_rdy_o  = m_pi1_rdy_i &
                           (((r_state == GNT1) && !w_masked) || (r_pend && r_pown));
    assign gnt_o = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        if (!w_granted) begin
            w_hold_nxt = '0;
            if (s0_pi1_op_i != PINOOP)      w_state_nxt = GNT0;
            else if (s1_pi1_op_i != PINOOP) w_state_nxt = GNT1;
        end else if (w_handover) begin
            w_hold_nxt = '0;
            if (w_oth_op != PINOOP) w_state_nxt = w_own ? GNT0 : GNT1;
            else                    w_state_nxt = IDLE;
        end else if (w_own_op == PINOOP) begin
            w_hold_nxt = '0;
        end else if (w_accept && (w_oth_op != PINOOP) && (r_hold != 8'hFF)) begin
            w_hold_nxt = r_hold + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_pown  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_accept) begin
                r_pend <= 1'b1;
                r_pown <= w_own;
            end else if (m_pi1_rdy_i) begin
                r_pend <= 1'b0;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{XADDRBITSZ[0]};
endmodule

// File: tb/tb_fbdev_pi1arb.sv
// Bench for fbdev_pi1arb: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant owner, queue of outstanding responses).
module tb_fbdev_pi1arb;
    localparam int XW = 32;
    localparam int HM = 4;
    localparam int AW = XW - $clog2(XW/8);
    localparam int SW = XW/8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    s0_op, s1_op, m_op, gnt;
    logic [AW-1:0] s0_addr, s1_addr, m_addr;
    logic [XW-1:0] s0_wd, s1_wd, s0_rd, s1_rd, m_wd, m_rd;
    logic [SW-1:0] s0_sel, s1_sel, m_sel;
    logic          s0_rdy, s1_rdy, m_rdy;

    fbdev_pi1arb #(.XARCHBITSZ(XW), .HOLDMAX(HM)) dut (
        .clk_i(clk), .rst_i(rst),
        .s0_pi1_op_i(s0_op), .s0_pi1_addr_i(s0_addr), .s0_pi1_data_i(s0_wd),
        .s0_pi1_data_o(s0_rd), .s0_pi1_sel_i(s0_sel), .s0_pi1_rdy_o(s0_rdy),
        .s1_pi1_op_i(s1_op), .s1_pi1_addr_i(s1_addr), .s1_pi1_data_i(s1_wd),
        .s1_pi1_data_o(s1_rd), .s1_pi1_sel_i(s1_sel), .s1_pi1_rdy_o(s1_rdy),
        .m_pi1_op_o(m_op), .m_pi1_addr_o(m_addr), .m_pi1_data_o(m_wd),
        .m_pi1_data_i(m_rd), .m_pi1_sel_o(m_sel), .m_pi1_rdy_i(m_rdy),
        .gnt_o(gnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: who holds the grant (0 none, 1 s0, 2 s1), outstanding response owners, streak length.
    int mg;
    int pendq[$];
    int streak;

    bit acc0, acc1;
    logic [1:0]    smp_gnt, smp_mop;
    logic [AW-1:0] smp_maddr;
    logic          smp_r0, smp_r1;
    logic [XW-1:0] smp_d1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mg = 0;
        pendq.delete();
        streak = 0;
    endtask

    task automatic new_req(output logic [1:0] op, output logic [AW-1:0] a,
                           output logic [XW-1:0] d, output logic [SW-1:0] s);
        op = 2'($urandom_range(1, 3));
        a  = AW'($urandom);
        d  = $urandom;
        s  = SW'($urandom);
    endtask

    task automatic tick();
        bit granted, mask, er0, er1, macc, ho;
        int own;
        logic [1:0]    ownop, othop, emop;
        logic [AW-1:0] eaddr;
        logic [XW-1:0] ewd;
        logic [SW-1:0] esel;
        @(negedge clk);
        granted = (mg != 0);
        own     = (mg == 2) ? 1 : 0;
        ownop   = (own == 1) ? s1_op : s0_op;
        othop   = (own == 1) ? s0_op : s1_op;
        mask    = granted && (streak >= HM - 1) && (othop != 2'd0);
        emop = 2'd0; eaddr = '0; ewd = '0; esel = '0;
        if (granted && !mask) begin
            emop  = ownop;
            eaddr = (own == 1) ? s1_addr : s0_addr;
            ewd   = (own == 1) ? s1_wd   : s0_wd;
            esel  = (own == 1) ? s1_sel  : s0_sel;
        end
        er0 = m_rdy && (((mg == 1) && !mask) || ((pendq.size() > 0) && (pendq[0] == 0)));
        er1 = m_rdy && (((mg == 2) && !mask) || ((pendq.size() > 0) && (pendq[0] == 1)));
        chk("gnt", 64'(gnt), 64'(mg));
        chk("m_op", 64'(m_op), 64'(emop));
        chk("m_addr", 64'(m_addr), 64'(eaddr));
        chk("m_wdata", 64'(m_wd), 64'(ewd));
        chk("m_sel", 64'(m_sel), 64'(esel));
        chk("s0_rdy", 64'(s0_rdy), 64'(er0));
        chk("s1_rdy", 64'(s1_rdy), 64'(er1));
        chk("s0_rdata", 64'(s0_rd), 64'(m_rd));
        chk("s1_rdata", 64'(s1_rd), 64'(m_rd));
        smp_gnt = gnt; smp_mop = m_op; smp_maddr = m_addr;
        smp_r0 = s0_rdy; smp_r1 = s1_rdy; smp_d1 = s1_rd;
        acc0 = (s0_op != 2'd0) && er0;
        acc1 = (s1_op != 2'd0) && er1;
        macc = (emop != 2'd0) && m_rdy;
        ho   = granted && ((ownop == 2'd0) || mask) && ((pendq.size() == 0) || m_rdy);
        if (m_rdy && pendq.size() > 0) void'(pendq.pop_front());
        if (macc) pendq.push_back(own);
        if (pendq.size() > 1) chk("one_outstanding", 64'(pendq.size()), 64'd1);
        if (!granted) begin
            mg = (s0_op != 2'd0) ? 1 : ((s1_op != 2'd0) ? 2 : 0);
            streak = 0;
        end else if (ho) begin
            mg = (othop != 2'd0) ? ((own == 1) ? 1 : 2) : 0;
            streak = 0;
        end else if (ownop == 2'd0) begin
            streak = 0;
        end else if (macc && (othop != 2'd0) && streak < 255) begin
            streak++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt0, mask_cyc, s1_cyc, cyc;
        s0_op = 0; s1_op = 0; s0_addr = 0; s1_addr = 0; s0_wd = 0; s1_wd = 0;
        s0_sel = 0; s1_sel = 0; m_rdy = 1'b1; m_rd = 32'h0;
        model_reset();
        #2;
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_m_op", 64'(m_op), 64'd0);
        chk("reset_s0_rdy", 64'(s0_rdy), 64'd0);
        chk("reset_s1_rdy", 64'(s1_rdy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read from s0
        s0_op = 2'd2; s0_addr = AW'(32'h100); m_rd = 32'hCAFE0001;
        tick();
        chk("rd_c0_gnt", 64'(smp_gnt), 64'd0);
        tick();
        chk("rd_c1_gnt", 64'(smp_gnt), 64'd1);
        chk("rd_c1_op", 64'(smp_mop), 64'd2);
        chk("rd_c1_addr", 64'(smp_maddr), 64'h100);
        s0_op = 2'd0;
        tick();
        chk("rd_c2_s0rdy", 64'(smp_r0), 64'd1);
        chk("rd_c2_s1rdy", 64'(smp_r1), 64'd0);
        tick();
        chk("rd_c3_idle", 64'(smp_gnt), 64'd0);

        // Tie from IDLE
        s0_op = 2'd1; s0_addr = AW'(32'hA0); s1_op = 2'd2; s1_addr = AW'(32'hB0);
        tick();
        tick();
        chk("tie_c1_gnt", 64'(smp_gnt), 64'd1);
        chk("tie_c1_addr", 64'(smp_maddr), 64'hA0);
        s0_op = 2'd0;
        tick();
        chk("tie_c2_gnt", 64'(smp_gnt), 64'd1);
        tick();
        chk("tie_c3_gnt", 64'(smp_gnt), 64'd2);
        chk("tie_c3_addr", 64'(smp_maddr), 64'hB0);
        s1_op = 2'd0;
        repeat (3) tick();

        // Starvation guard
        s0_op = 2'd2; s0_addr = AW'(32'h200); s1_op = 2'd2; s1_addr = AW'(32'h300);
        cnt0 = 0; mask_cyc = -1; s1_cyc = -1;
        for (int c = 0; c < 40 && s1_cyc < 0; c++) begin
            tick();
            if (smp_gnt == 2'd1 && smp_mop != 2'd0 && m_rdy) cnt0++;
            if (mask_cyc < 0 && smp_gnt == 2'd1 && s0_op != 2'd0 && smp_mop == 2'd0) mask_cyc = c;
            if (smp_gnt == 2'd2 && smp_mop != 2'd0 && m_rdy) s1_cyc = c;
            if (acc0) s0_addr = s0_addr + AW'(1);
            if (acc1) s1_op = 2'd0;
        end
        chk("starve_s0_ops", 64'(cnt0), 64'd3);
        chk("starve_mask_seen", 64'(mask_cyc >= 0), 64'd1);
        chk("starve_s1_accepted", 64'(s1_cyc >= 0), 64'd1);
        chk("starve_s1_latency", 64'((s1_cyc - mask_cyc) <= 3 && s1_cyc > mask_cyc), 64'd1);
        s0_op = 2'd0; s1_op = 2'd0;
        repeat (4) tick();

        // Response routing with slow memory
        s1_op = 2'd2; s1_addr = AW'(32'h400);
        tick();
        tick();
        chk("route_c1_gnt", 64'(smp_gnt), 64'd2);
        s1_op = 2'd0; s0_op = 2'd2; s0_addr = AW'(32'h500); m_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("route_wait_s0rdy", 64'(smp_r0), 64'd0);
            chk("route_wait_s1rdy", 64'(smp_r1), 64'd0);
            chk("route_wait_gnt", 64'(smp_gnt), 64'd2);
        end
        m_rdy = 1'b1; m_rd = 32'hBEEF0002;
        tick();
        chk("route_s1rdy", 64'(smp_r1), 64'd1);
        chk("route_s1data", 64'(smp_d1), 64'hBEEF0002);
        chk("route_s0rdy", 64'(smp_r0), 64'd0);
        tick();
        chk("route_gnt0", 64'(smp_gnt), 64'd1);
        chk("route_addr", 64'(smp_maddr), 64'h500);
        s0_op = 2'd0;
        repeat (3) tick();

        // Reset while a response is outstanding
        s0_op = 2'd2; s0_addr = AW'(32'h600);
        tick();
        tick();
        s0_op = 2'd0; m_rdy = 1'b0;
        tick();
        #2;
        rst = 1'b1; m_rdy = 1'b1; s1_op = 2'd1;
        #1;
        chk("rst_mid_gnt", 64'(gnt), 64'd0);
        chk("rst_mid_m_op", 64'(m_op), 64'd0);
        chk("rst_mid_s0rdy", 64'(s0_rdy), 64'd0);
        chk("rst_mid_s1rdy", 64'(s1_rdy), 64'd0);
        model_reset();
        s1_op = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_s0rdy", 64'(smp_r0), 64'd0);
            chk("post_rst_s1rdy", 64'(smp_r1), 64'd0);
        end

        // Randomized traffic
        cyc = 0;
        repeat (3000) begin
            tick();
            cyc++;
            if (s0_op != 2'd0) begin
                if (acc0) begin
                    if ($urandom_range(0, 1) == 1) new_req(s0_op, s0_addr, s0_wd, s0_sel);
                    else s0_op = 2'd0;
                end
            end else if ($urandom_range(0, 9) < 3) new_req(s0_op, s0_addr, s0_wd, s0_sel);
            if (s1_op != 2'd0) begin
                if (acc1) begin
                    if ($urandom_range(0, 1) == 1) new_req(s1_op, s1_addr, s1_wd, s1_sel);
                    else s1_op = 2'd0;
                end
            end else if ($urandom_range(0, 9) < 4) new_req(s1_op, s1_addr, s1_wd, s1_sel);
            m_rdy = ($urandom_range(0, 9) < 7);
            m_rd  = $urandom;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
